mem_access_unit: RTL

Memory-stage load/store unit, sitting directly downstream of the integer ALU in the execute path. Accepts one decoded load/store instruction plus register operands, computes the effective byte address, drives a word-wide synchronous data memory with byte enables, and returns sign- or zero-extended load data through the same `enabled`/`completed` handshake the execute stage already uses. Multi-cycle: a small FSM with a read-latency counter tracks each access.

---
 rtl/mem_access_unit.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage load/store unit. Accepts one decoded load/store plus its
// register operands, forms the effective byte address, drives a word-wide
// synchronous data memory with byte enables and returns sign- or
// zero-extended load data through the enabled/completed handshake.
//
// Parameters:
//   ADDR_W        word-address width of the data memory
//   READ_LATENCY  cycles from the request cycle to valid mem_rdata (>= 1)
//
// Ports:
//   clk         clock, rising edge
//   rstn        asynchronous reset, active HIGH despite the name
//   enabled     start strobe, only looked at while idle
//   instr[39:0] decoded instruction, packed as
//                 [31:0] imm
//                 [32] lb  [33] lh  [34] lw  [35] lbu
//                 [36] lhu [37] sb  [38] sh  [39] sw
//   rs1         base register value
//   rs2         store data register value
//   completed   one-cycle pulse when the result is final
//   misaligned  alignment fault flag, valid with completed
//   rd          load result (0 for stores, faults and non-memory ops)
//   mem_en      memory request strobe
//   mem_addr    memory word address
//   mem_we      byte-lane write enables (bit i = bits [8i+7:8i])
//   mem_wdata   memory write data
//   mem_rdata   memory read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enabled,
    input  logic [39:0]       instr,
    input  logic [31:0]       rs1,
    input  logic [31:0]       rs2,
    output logic              completed,
    output logic              misaligned,
    output logic [31:0]       rd,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              isLoad_q, isLoad_d;
    logic              isSigned_q, isSigned_d;
    logic              completed_q, completed_d;
    logic              misaligned_q, misaligned_d;
    logic [31:0]       rd_q, rd_d;
    logic              memEn_q, memEn_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [3:0]        memWe_q, memWe_d;
    logic [31:0]       memWdata_q, memWdata_d;

    logic        opLb, opLh, opLw, opLbu, opLhu, opSb, opSh, opSw;
    logic        anyLoad, anyStore, accByte, accHalf, accWord, badAlign;
    logic [31:0] ea;
    logic [1:0]  off;
    logic [31:0] lane;
    logic [31:0] loadResult;

    // Decode the one-hot memory flags and form the effective address.
    always_comb begin
        opLb     = instr[32];
        opLh     = instr[33];
        opLw     = instr[34];
        opLbu    = instr[35];
        opLhu    = instr[36];
        opSb     = instr[37];
        opSh     = instr[38];
        opSw     = instr[39];
        anyLoad  = opLb | opLh | opLw | opLbu | opLhu;
        anyStore = opSb | opSh | opSw;
        accByte  = opLb | opLbu | opSb;
        accHalf  = opLh | opLhu | opSh;
        accWord  = opLw | opSw;
        ea       = rs1 + instr[31:0];
        off      = ea[1:0];
        // Halfwords need an even offset, words need offset zero.
        badAlign = (accHalf & off[0]) | (accWord & (off != 2'd0));
    end

    // Pull the addressed lane down to bit 0 and extend it to 32 bits.
    always_comb begin
        lane       = mem_rdata >> {off_q, 3'b000};
        loadResult = lane;
        case (size_q)
            SZ_BYTE: loadResult = isSigned_q ? {{24{lane[7]}}, lane[7:0]}
                                             : {24'h0, lane[7:0]};
            SZ_HALF: loadResult = isSigned_q ? {{16{lane[15]}}, lane[15:0]}
                                             : {16'h0, lane[15:0]};
            default: loadResult = lane;
        endcase
    end

    // Next-state and next-output logic. Every output is a register, so the
    // values computed here appear on the ports one cycle later.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        isLoad_d     = isLoad_q;
        isSigned_d   = isSigned_q;
        completed_d  = 1'b0;
        misaligned_d = misaligned_q;
        rd_d         = rd_q;
        memEn_d      = memEn_q;
        memAddr_d    = memAddr_q;
        memWe_d      = memWe_q;
        memWdata_d   = memWdata_q;

        case (state_q)
            IDLE: begin
                if (enabled) begin
                    off_d        = off;
                    isLoad_d     = anyLoad;
                    isSigned_d   = opLb | opLh;
                    size_d       = accByte ? SZ_BYTE : (accHalf ? SZ_HALF : SZ_WORD);
                    rd_d         = 32'h0;
                    misaligned_d = 1'b0;
                    if (!(anyLoad | anyStore)) begin
                        state_d     = DONE;
                        completed_d = 1'b1;
                    end else if (badAlign) begin
                        state_d      = DONE;
                        completed_d  = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = ACCESS;
                        memEn_d   = 1'b1;
                        memAddr_d = ea[ADDR_W+1:2];
                        memWe_d   = 4'b0000;
                        // Stores replicate the data across lanes so the
                        // byte enables alone pick the destination bytes.
                        if (opSb) begin
                            memWdata_d = {4{rs2[7:0]}};
                            memWe_d    = 4'b0001 << off;
                        end else if (opSh) begin
                            memWdata_d = {2{rs2[15:0]}};
                            memWe_d    = 4'b0011 << off;
                        end else if (opSw) begin
                            memWdata_d = rs2;
                            memWe_d    = 4'b1111;
                        end
                    end
                end
            end
            ACCESS: begin
                memEn_d = 1'b0;
                memWe_d = 4'b0000;
                if (isLoad_q) begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d     = DONE;
                    completed_d = 1'b1;
                end
            end
            WAIT: begin
                // A zero count marks the cycle in which mem_rdata is valid.
                if (cnt_q == '0) begin
                    rd_d        = loadResult;
                    state_d     = DONE;
                    completed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access immediately.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_q        <= 2'd0;
            size_q       <= SZ_BYTE;
            isLoad_q     <= 1'b0;
            isSigned_q   <= 1'b0;
            completed_q  <= 1'b0;
            misaligned_q <= 1'b0;
            rd_q         <= 32'h0;
            memEn_q      <= 1'b0;
            memAddr_q    <= '0;
            memWe_q      <= 4'b0000;
            memWdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            isLoad_q     <= isLoad_d;
            isSigned_q   <= isSigned_d;
            completed_q  <= completed_d;
            misaligned_q <= misaligned_d;
            rd_q         <= rd_d;
            memEn_q      <= memEn_d;
            memAddr_q    <= memAddr_d;
            memWe_q      <= memWe_d;
            memWdata_q   <= memWdata_d;
        end
    end

    assign completed  = completed_q;
    assign misaligned = misaligned_q;
    assign rd         = rd_q;
    assign mem_en     = memEn_q;
    assign mem_addr   = memAddr_q;
    assign mem_we     = memWe_q;
    assign mem_wdata  = memWdata_q;

endmodule
